// File: rtl/memc_pkg.sv
// rtl/memc_pkg.sv - shared encodings for the MEMC DMA/CPU memory port arbiter
//
// Purpose: grant-owner encodings (also the read-data routing code on grant_o),
//          wishbone cycle-type-identifier values, and the arbiter state type.
// Ports:   none (package).
package memc_pkg;

    localparam logic [1:0] GNT_CPU = 2'd0;
    localparam logic [1:0] GNT_VID = 2'd1;
    localparam logic [1:0] GNT_CUR = 2'd2;
    localparam logic [1:0] GNT_SND = 2'd3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DMA  = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memc_dma_arbiter_if.sv
// rtl/memc_dma_arbiter_if.sv - requester and wishbone memory port bundle for the arbiter
//
// Purpose: groups the CPU request port, the three DMA request ports and the
//          MEM_* wishbone master port.
// Modports:
//   master - arbiter view: consumes requests and mem_ack_i, drives acks,
//            grant_o and the mem_*_o bus.
//   slave  - environment view: the requesters plus the memory slave.
interface memc_dma_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              cpu_req;
    logic              cpu_we;
    logic [3:0]        cpu_sel;
    logic [ADDR_W-1:0] cpu_adr;
    logic              cpu_ack;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_adr;
    logic              vid_ack;
    logic              cur_req;
    logic [ADDR_W-1:0] cur_adr;
    logic              cur_ack;
    logic              snd_req;
    logic [ADDR_W-1:0] snd_adr;
    logic              snd_ack;
    logic [1:0]        grant_o;
    logic              mem_cyc_o;
    logic              mem_stb_o;
    logic              mem_we_o;
    logic [3:0]        mem_sel_o;
    logic [2:0]        mem_cti_o;
    logic [ADDR_W-1:0] mem_adr_o;
    logic              mem_ack_i;

    modport master (
        input  cpu_req, cpu_we, cpu_sel, cpu_adr,
        input  vid_req, vid_adr, cur_req, cur_adr, snd_req, snd_adr,
        input  mem_ack_i,
        output cpu_ack, vid_ack, cur_ack, snd_ack, grant_o,
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_adr_o
    );

    modport slave (
        output cpu_req, cpu_we, cpu_sel, cpu_adr,
        output vid_req, vid_adr, cur_req, cur_adr, snd_req, snd_adr,
        output mem_ack_i,
        input  cpu_ack, vid_ack, cur_ack, snd_ack, grant_o,
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_adr_o
    );

endinterface

// File: rtl/memc_prio_enc.sv
// rtl/memc_prio_enc.sv - fixed-priority owner pick for the memory port arbiter
//
// Purpose: combinational pick; an owed CPU slot beats every DMA requester,
//          otherwise vid > cur > snd > cpu.
// Ports:
//   debt_cpu  in   CPU has a pending request and is owed a slot
//   vid/cur/snd/cpu in  raw request lines
//   grant     out  2-bit owner code (memc_pkg GNT_*)
//   valid     out  some requester is asking
module memc_prio_enc
    import memc_pkg::*;
(
    input  logic       debt_cpu,
    input  logic       vid,
    input  logic       cur,
    input  logic       snd,
    input  logic       cpu,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = GNT_CPU;
        valid = 1'b1;
        if (debt_cpu)  grant = GNT_CPU;
        else if (vid)  grant = GNT_VID;
        else if (cur)  grant = GNT_CUR;
        else if (snd)  grant = GNT_SND;
        else if (cpu)  grant = GNT_CPU;
        else           valid = 1'b0;
    end

endmodule

// File: rtl/memc_dma_arbiter.sv
// rtl/memc_dma_arbiter.sv - CPU/video/cursor/sound arbiter for the MEMC wishbone port
//
// Purpose: DMA requesters get fixed-priority BURST_LEN-word incrementing
//          bursts; after each burst the CPU is owed CPU_SLOT single accesses
//          while it keeps requesting. One IDLE cycle separates every grant.
// Ports:
//   clkcpu  in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   bus     memc_dma_arbiter_if.master - requesters, acks, grant_o, MEM_* port
module memc_dma_arbiter
    import memc_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int BURST_LEN = 4,
    parameter int CPU_SLOT  = 1
) (
    input  logic                 clkcpu,
    input  logic                 rst_n,
    memc_dma_arbiter_if.master   bus
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int DW = $clog2(CPU_SLOT + 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    arb_state_t        state;
    logic [1:0]        grant;
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [2:0]        cti;
    logic [ADDR_W-1:0] adr;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     beat_nxt;
    logic [DW-1:0]     debt;

    logic [1:0]        pick;
    logic              pick_valid;
    logic [ADDR_W-1:0] dma_adr;
    logic              mem_ack;

    memc_prio_enc u_prio (
        .debt_cpu (debt != '0 && bus.cpu_req),
        .vid      (bus.vid_req),
        .cur      (bus.cur_req),
        .snd      (bus.snd_req),
        .cpu      (bus.cpu_req),
        .grant    (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        dma_adr = bus.vid_adr;
        case (pick)
            GNT_CUR: dma_adr = bus.cur_adr;
            GNT_SND: dma_adr = bus.snd_adr;
            default: dma_adr = bus.vid_adr;
        endcase
    end

    // Counter wraps inside the aligned block; upper address bits never change.
    assign beat_nxt = beat + 1'b1;

    // Stray acks with no cycle open are discarded here.
    assign mem_ack = cyc & bus.mem_ack_i;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= GNT_CPU;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            we    <= 1'b0;
            sel   <= 4'h0;
            cti   <= CTI_CLASSIC;
            adr   <= '0;
            beat  <= '0;
            debt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Unused CPU slots are forfeited, never banked.
                    if (!bus.cpu_req)
                        debt <= '0;
                    if (pick_valid) begin
                        grant <= pick;
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        if (pick == GNT_CPU) begin
                            state <= ST_CPU;
                            we    <= bus.cpu_we;
                            sel   <= bus.cpu_sel;
                            adr   <= bus.cpu_adr;
                            cti   <= CTI_CLASSIC;
                        end else begin
                            state <= ST_DMA;
                            we    <= 1'b0;
                            sel   <= 4'hF;
                            adr   <= {dma_adr[ADDR_W-1:BW], {BW{1'b0}}};
                            cti   <= CTI_INCR;
                            beat  <= '0;
                        end
                    end
                end
                ST_DMA: begin
                    if (mem_ack) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_IDLE;
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            sel   <= 4'h0;
                            cti   <= CTI_CLASSIC;
                            debt  <= DW'(CPU_SLOT);
                        end else begin
                            beat <= beat_nxt;
                            adr  <= {adr[ADDR_W-1:BW], beat_nxt};
                            cti  <= (beat_nxt == LAST_BEAT) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end
                ST_CPU: begin
                    if (mem_ack) begin
                        state <= ST_IDLE;
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        we    <= 1'b0;
                        sel   <= 4'h0;
                        if (debt != '0)
                            debt <= debt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = (state == ST_CPU) & mem_ack;
    assign bus.vid_ack   = (state == ST_DMA) & (grant == GNT_VID) & mem_ack;
    assign bus.cur_ack   = (state == ST_DMA) & (grant == GNT_CUR) & mem_ack;
    assign bus.snd_ack   = (state == ST_DMA) & (grant == GNT_SND) & mem_ack;
    assign bus.grant_o   = grant;
    assign bus.mem_cyc_o = cyc;
    assign bus.mem_stb_o = stb;
    assign bus.mem_we_o  = we;
    assign bus.mem_sel_o = sel;
    assign bus.mem_cti_o = cti;
    assign bus.mem_adr_o = adr;

endmodule

// File: tb/tb_memc_dma_arbiter.sv
// tb/tb_memc_dma_arbiter.sv - directed self-checking bench for memc_dma_arbiter
module tb_memc_dma_arbiter;
    import memc_pkg::*;

    localparam int ADDR_W    = 22;
    localparam int BURST_LEN = 4;
    localparam int CPU_SLOT  = 1;

    logic clkcpu = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   owners[$];

    memc_dma_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    memc_dma_arbiter #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .CPU_SLOT  (CPU_SLOT)
    ) dut (
        .clkcpu (clkcpu),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clkcpu = ~clkcpu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkcpu);
        #1;
    endtask

    // Records the owner of every ack pulse in order; optionally drops a
    // requester on its first ack and checks CPU service spacing.
    task automatic observe(input int n, input bit drop, input int max_gap);
        int last = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.vid_ack) begin owners.push_back(1); if (drop) bus.vid_req = 1'b0; end
            if (bus.cur_ack) begin owners.push_back(2); if (drop) bus.cur_req = 1'b0; end
            if (bus.snd_ack) begin owners.push_back(3); if (drop) bus.snd_req = 1'b0; end
            if (bus.cpu_ack) begin
                owners.push_back(0);
                if (max_gap > 0) check("cpu_gap", 32'((i - last) <= max_gap), 32'd1);
                last = i;
                if (drop) bus.cpu_req = 1'b0;
            end
        end
    endtask

    task automatic check_owners(input string tag, input int exp[$]);
        check({tag, "_count"}, 32'(owners.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < owners.size()) ? 32'(owners[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    task automatic run_burst(input string tag, input logic [21:0] start, input logic [21:0] base);
        bus.vid_adr   = start;
        bus.vid_req   = 1'b1;
        bus.mem_ack_i = 1'b1;
        for (int i = 0; i < BURST_LEN; i++) begin
            tick();
            if (i == 0) bus.vid_req = 1'b0;
            check({tag, "_adr"}, 32'(bus.mem_adr_o), 32'(base + 22'(i)));
            check({tag, "_cti"}, 32'(bus.mem_cti_o), (i == BURST_LEN - 1) ? 32'h7 : 32'h2);
            check({tag, "_ack"}, 32'({bus.vid_ack, bus.mem_cyc_o, bus.mem_stb_o}), 32'h7);
        end
        tick();
        check({tag, "_end"}, 32'({bus.mem_cyc_o, bus.vid_ack}), 32'h0);
        check({tag, "_grant_hold"}, 32'(bus.grant_o), 32'(GNT_VID));
        bus.mem_ack_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 4'h0; bus.cpu_adr = '0;
        bus.vid_req = 1'b0; bus.vid_adr = '0;
        bus.cur_req = 1'b0; bus.cur_adr = '0;
        bus.snd_req = 1'b0; bus.snd_adr = '0;
        bus.mem_ack_i = 1'b0;

        repeat (3) tick();
        check("reset_bus", 32'({bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.mem_sel_o, bus.mem_cti_o}), 32'h0);
        check("reset_grant_adr", 32'({bus.grant_o, bus.mem_adr_o}), 32'h0);
        rst_n = 1'b1;

        // Reset mid-burst, during beat 2 of a video burst
        bus.vid_adr = 22'h000100; bus.vid_req = 1'b1; bus.mem_ack_i = 1'b1;
        tick(); tick(); tick();
        check("mid_adr", 32'(bus.mem_adr_o), 32'h102);
        check("mid_grant", 32'(bus.grant_o), 32'(GNT_VID));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({bus.mem_cyc_o, bus.mem_stb_o, bus.vid_ack, bus.cpu_ack, bus.grant_o}), 32'h0);
        tick();
        bus.vid_req = 1'b0; bus.mem_ack_i = 1'b0; rst_n = 1'b1;
        tick();

        // Aligned and misaligned video bursts
        run_burst("aligned", 22'h000100, 22'h000100);
        run_burst("wrap", 22'h000106, 22'h000104);

        // Video, sound and CPU requested together
        owners.delete();
        bus.vid_req = 1'b1; bus.snd_req = 1'b1; bus.cpu_req = 1'b1; bus.mem_ack_i = 1'b1;
        observe(16, 1'b1, 0);
        check_owners("mix_order", '{1, 1, 1, 1, 0, 3, 3, 3, 3});
        check("mix_idle", 32'(bus.mem_cyc_o), 32'h0);

        // Video and CPU both held: CPU interleaves after each burst
        owners.delete();
        bus.vid_req = 1'b1; bus.cpu_req = 1'b1;
        observe(21, 1'b0, BURST_LEN + 3);
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        check_owners("interleave", '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0});
        tick(); tick();
        check("interleave_idle", 32'(bus.mem_cyc_o), 32'h0);

        // Stray acks while idle, then a CPU write at the top of the address space
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray", 32'({bus.cpu_ack, bus.vid_ack, bus.cur_ack, bus.snd_ack, bus.mem_cyc_o}), 32'h0);
        end
        bus.mem_ack_i = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_sel = 4'b0011; bus.cpu_adr = 22'h3FFFFF;
        tick();
        check("wr_attr", 32'({bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.mem_sel_o, bus.mem_cti_o}), 32'b1110011000);
        check("wr_adr", 32'(bus.mem_adr_o), 32'h3FFFFF);
        check("wr_grant", 32'(bus.grant_o), 32'(GNT_CPU));
        check("wr_wait", 32'(bus.cpu_ack), 32'h0);
        bus.cpu_we = 1'b0; bus.cpu_sel = 4'h0;
        bus.mem_ack_i = 1'b1;
        #1;
        check("wr_ack", 32'(bus.cpu_ack), 32'h1);
        bus.cpu_req = 1'b0;
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        check("wr_done", 32'({bus.mem_cyc_o, bus.cpu_ack}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
